// File: rtl/v3_pulse_extractor_pkg.sv
// Shared defaults and types for the v3 shaping chain: sample width, pulse
// extractor tuning, the event record layout and the extractor FSM states.
package v3_filter_parameters;

  localparam int SIZE_ADC_DATA = 16;
  localparam int TS_WIDTH      = 32;
  localparam int WIDTH_BITS    = 10;
  localparam int MAX_WIDTH     = 512;
  localparam int HYST          = 4;
  localparam int DEAD_TIME     = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ABOVE    = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_DEAD     = 2'd3
  } pe_state_e;

  typedef struct packed {
    logic signed [SIZE_ADC_DATA-1:0] amp;
    logic [TS_WIDTH-1:0]             ts;
    logic [WIDTH_BITS-1:0]           width;
    logic                            pileup;
  } event_rec_t;

endpackage

// File: rtl/v3_pulse_extractor_event_slot.sv
// One-entry valid/ready holding register for event records, plus a
// saturating count of events that arrived while a record was still held.
module v3_event_slot #(
  parameter int REC_W  = 59,
  parameter int LOST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              emit_i,
  input  logic [REC_W-1:0]  rec_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [REC_W-1:0]  rec_o,
  output logic [LOST_W-1:0] lost_count_o
);

  logic              valid_q, valid_d;
  logic [REC_W-1:0]  rec_q, rec_d;
  logic [LOST_W-1:0] lost_q, lost_d;

  // Load on emit when empty or draining; otherwise drop and count.
  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    lost_d  = lost_q;
    if (emit_i) begin
      if (!valid_q || out_ready_i) begin
        rec_d   = rec_i;
        valid_d = 1'b1;
      end else if (lost_q != {LOST_W{1'b1}}) begin
        lost_d = lost_q + LOST_W'(1);
      end else begin
        lost_d = lost_q;
      end
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      rec_q   <= {REC_W{1'b0}};
      lost_q  <= {LOST_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
      lost_q  <= lost_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign rec_o        = rec_q;
  assign lost_count_o = lost_q;

endmodule

// File: rtl/v3_pulse_extractor.sv
// Pulse detector on the shaped sample stream: threshold with hysteresis,
// peak/timestamp/width tracking, pile-up cut-off and post-event dead time.
module v3_pulse_extractor #(
  parameter int SIZE_ADC_DATA = v3_filter_parameters::SIZE_ADC_DATA,
  parameter int TS_WIDTH      = v3_filter_parameters::TS_WIDTH,
  parameter int WIDTH_BITS    = v3_filter_parameters::WIDTH_BITS,
  parameter int MAX_WIDTH     = v3_filter_parameters::MAX_WIDTH,
  parameter int HYST          = v3_filter_parameters::HYST,
  parameter int DEAD_TIME     = v3_filter_parameters::DEAD_TIME
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [SIZE_ADC_DATA-1:0] filter_data,
  input  logic signed [SIZE_ADC_DATA-1:0] thr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [SIZE_ADC_DATA-1:0] out_amp,
  output logic [TS_WIDTH-1:0]             out_ts,
  output logic [WIDTH_BITS-1:0]           out_width,
  output logic                            out_pileup,
  output logic [15:0]                     lost_count
);
  import v3_filter_parameters::*;

  localparam int DW    = SIZE_ADC_DATA;
  localparam int CW    = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam int REC_W = DW + TS_WIDTH + WIDTH_BITS + 1;

  pe_state_e               state_q, state_d;
  logic signed [DW-1:0]    max_q, max_d;
  logic [TS_WIDTH-1:0]     ts_q, peak_ts_q, peak_ts_d;
  logic [WIDTH_BITS-1:0]   width_q, width_d;
  logic [CW-1:0]           dead_q, dead_d;

  logic signed [DW:0]      thr_ext_s;
  logic signed [DW-1:0]    thr_lo_s;
  logic                    emit_s;
  logic signed [DW-1:0]    emit_amp_s;
  logic [TS_WIDTH-1:0]     emit_ts_s;
  logic [WIDTH_BITS-1:0]   emit_width_s;
  logic                    emit_pileup_s;
  logic [REC_W-1:0]        rec_out_s;

  // Lower hysteresis level; only negative overflow is possible, so clamp there.
  always_comb begin
    thr_ext_s = $signed({thr[DW-1], thr}) - $signed((DW+1)'(HYST));
    if (thr_ext_s[DW] != thr_ext_s[DW-1]) begin
      thr_lo_s = $signed({1'b1, {(DW-1){1'b0}}});
    end else begin
      thr_lo_s = thr_ext_s[DW-1:0];
    end
  end

  // FSM next state, peak tracking and the record handed to the slot.
  always_comb begin
    state_d       = state_q;
    max_d         = max_q;
    peak_ts_d     = peak_ts_q;
    width_d       = width_q;
    dead_d        = dead_q;
    emit_s        = 1'b0;
    emit_amp_s    = max_q;
    emit_ts_s     = peak_ts_q;
    emit_width_s  = width_q;
    emit_pileup_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (filter_data > thr) begin
          max_d     = filter_data;
          peak_ts_d = ts_q;
          width_d   = WIDTH_BITS'(1);
          state_d   = ST_ABOVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ABOVE: begin
        // Strict compare keeps the earliest sample of a tied peak.
        if (filter_data > max_q) begin
          max_d     = filter_data;
          peak_ts_d = ts_q;
        end else begin
          max_d = max_q;
        end
        emit_amp_s = max_d;
        emit_ts_s  = peak_ts_d;
        if (filter_data < thr_lo_s) begin
          emit_s  = 1'b1;
          dead_d  = {CW{1'b0}};
          state_d = ST_DEAD;
        end else if (width_q == WIDTH_BITS'(MAX_WIDTH - 1)) begin
          width_d       = WIDTH_BITS'(MAX_WIDTH);
          emit_s        = 1'b1;
          emit_width_s  = width_d;
          emit_pileup_s = 1'b1;
          state_d       = ST_WAIT_LOW;
        end else begin
          width_d = width_q + WIDTH_BITS'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (filter_data < thr_lo_s) begin
          dead_d  = {CW{1'b0}};
          state_d = ST_DEAD;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_DEAD: begin
        if (dead_q == CW'(DEAD_TIME - 1)) begin
          state_d = ST_IDLE;
        end else begin
          dead_d = dead_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, tracking registers and the free-running timestamp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      max_q     <= {DW{1'b0}};
      peak_ts_q <= {TS_WIDTH{1'b0}};
      width_q   <= {WIDTH_BITS{1'b0}};
      dead_q    <= {CW{1'b0}};
      ts_q      <= {TS_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      peak_ts_q <= peak_ts_d;
      width_q   <= width_d;
      dead_q    <= dead_d;
      ts_q      <= ts_q + TS_WIDTH'(1);
    end
  end

  v3_event_slot #(
    .REC_W  (REC_W),
    .LOST_W (16)
  ) u_slot (
    .clk          (clk),
    .reset        (reset),
    .emit_i       (emit_s),
    .rec_i        ({emit_amp_s, emit_ts_s, emit_width_s, emit_pileup_s}),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .rec_o        (rec_out_s),
    .lost_count_o (lost_count)
  );

  assign out_amp    = rec_out_s[REC_W-1 -: DW];
  assign out_ts     = rec_out_s[WIDTH_BITS+1 +: TS_WIDTH];
  assign out_width  = rec_out_s[1 +: WIDTH_BITS];
  assign out_pileup = rec_out_s[0];

endmodule

// File: tb/tb_v3_pulse_extractor.sv
// Bench for v3_pulse_extractor: directed scenarios plus random streams, each
// checked every cycle against an index-based event model of the stream.
module tb_v3_pulse_extractor;

  localparam int DW   = 16;
  localparam int TSW  = 32;
  localparam int WB   = 10;
  localparam int MAXW = 512;
  localparam int HYST = 4;
  localparam int DEAD = 16;
  localparam int NMAX = 2048;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic signed [DW-1:0] filter_data = '0;
  logic signed [DW-1:0] thr = '0;
  logic                 out_ready = 1'b0;
  logic                 out_valid;
  logic signed [DW-1:0] out_amp;
  logic [TSW-1:0]       out_ts;
  logic [WB-1:0]        out_width;
  logic                 out_pileup;
  logic [15:0]          lost_count;

  v3_pulse_extractor #(
    .SIZE_ADC_DATA (DW), .TS_WIDTH (TSW), .WIDTH_BITS (WB),
    .MAX_WIDTH (MAXW), .HYST (HYST), .DEAD_TIME (DEAD)
  ) dut (
    .clk (clk), .reset (reset), .filter_data (filter_data), .thr (thr),
    .out_valid (out_valid), .out_ready (out_ready), .out_amp (out_amp),
    .out_ts (out_ts), .out_width (out_width), .out_pileup (out_pileup),
    .lost_count (lost_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus stream: sample and ready value driven before edge k (ts == k)
  int  xs [NMAX];
  bit  rs [NMAX];
  int  n;
  int  thr_i;

  // expected events, keyed by the sample index whose edge emits them
  bit     ev_v [NMAX];
  int     ev_amp [NMAX];
  longint ev_ts [NMAX];
  int     ev_w [NMAX];
  bit     ev_p [NMAX];

  // expected output-side state
  bit     m_valid;
  int     m_amp;
  longint m_ts;
  int     m_w;
  bit     m_p;
  int     m_lost;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic app(input int v, input bit r);
    if (n < NMAX) begin
      xs[n] = clamp(v);
      rs[n] = r;
      n++;
    end
  endtask

  task automatic app_n(input int v, input bit r, input int cnt);
    for (int i = 0; i < cnt; i++) app(v, r);
  endtask

  // Scan the stream for pulses: start, end/cut-off, peak, then skip dead time.
  task automatic build_events();
    int lo, k, s, j, m, amp, resume;
    longint pts;
    bit done;
    lo = (thr_i - HYST < -32768) ? -32768 : thr_i - HYST;
    for (int i = 0; i < NMAX; i++) ev_v[i] = 1'b0;
    k = 0;
    while (k < n) begin
      if (xs[k] > thr_i) begin
        s = k; amp = xs[s]; pts = s; j = s + 1; done = 1'b0; resume = n;
        while (!done && j < n) begin
          if (xs[j] > amp) begin amp = xs[j]; pts = j; end
          if (xs[j] < lo) begin
            ev_v[j] = 1'b1; ev_amp[j] = amp; ev_ts[j] = pts; ev_w[j] = j - s; ev_p[j] = 1'b0;
            resume = j + 1 + DEAD; done = 1'b1;
          end else if (j - s == MAXW - 1) begin
            ev_v[j] = 1'b1; ev_amp[j] = amp; ev_ts[j] = pts; ev_w[j] = MAXW; ev_p[j] = 1'b1;
            m = j + 1;
            while (m < n && xs[m] >= lo) m++;
            resume = m + 1 + DEAD; done = 1'b1;
          end
          j++;
        end
        k = resume;
      end else begin
        k++;
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_amp = 0; m_ts = 0; m_w = 0; m_p = 1'b0; m_lost = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    filter_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic run_range(input int a, input int b);
    for (int k = a; k < b; k++) begin
      filter_data = DW'(xs[k]);
      out_ready   = rs[k];
      thr         = DW'(thr_i);
      @(posedge clk);
      if (ev_v[k]) begin
        if (!m_valid || rs[k]) begin
          m_valid = 1'b1; m_amp = ev_amp[k]; m_ts = ev_ts[k]; m_w = ev_w[k]; m_p = ev_p[k];
        end else if (m_lost < 65535) begin
          m_lost++;
        end
      end else if (m_valid && rs[k]) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
      chk("valid", out_valid, m_valid);
      chk("amp", out_amp, m_amp);
      chk("ts", out_ts, m_ts);
      chk("width", out_width, m_w);
      chk("pileup", out_pileup, m_p);
      chk("lost", lost_count, m_lost);
    end
  endtask

  task automatic chk_rec(input string tag, input int amp, input longint ts, input int w, input bit p);
    chk({tag, "_amp"}, out_amp, amp);
    chk({tag, "_ts"}, out_ts, ts);
    chk({tag, "_width"}, out_width, w);
    chk({tag, "_pileup"}, out_pileup, p);
  endtask

  initial begin
    int r, len, v;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_amp", out_amp, 0);
    chk("rst_lost", lost_count, 0);

    // basic pulse: 150,300,250 above 100, ends on the 90 sample
    thr_i = 100; n = 0;
    app_n(0, 1, 4); app(150, 1); app(300, 1); app(250, 1); app(90, 1); app_n(0, 1, 30);
    build_events(); do_reset(); run_range(0, 8);
    chk("p1_valid_after_90", out_valid, 1);
    run_range(8, n);
    chk_rec("p1", 300, 5, 3, 1'b0);

    // hysteresis: 98 stays inside the band, 95 ends the pulse
    thr_i = 100; n = 0;
    app_n(0, 1, 4); app(102, 1); app(98, 1); app(103, 1); app(95, 1); app_n(0, 1, 30);
    build_events(); do_reset(); run_range(0, n);
    chk_rec("hyst", 103, 6, 3, 1'b0);

    // pile-up, band samples, a pulse inside dead time, then a normal pulse
    thr_i = 100; n = 0;
    app_n(500, 1, 600); app_n(97, 1, 5); app_n(50, 1, 5); app_n(200, 1, 3);
    app_n(0, 1, 17); app_n(200, 1, 3); app_n(0, 1, 30);
    build_events(); do_reset(); run_range(0, 620);
    chk_rec("pile", 500, 0, 512, 1'b1);
    run_range(620, n);
    chk_rec("post_pile", 200, 630, 3, 1'b0);

    // consumer stalled: second event dropped, then first record accepted
    thr_i = 100; n = 0;
    app_n(0, 0, 4); app_n(200, 0, 3); app(0, 0); app_n(0, 0, 30); app_n(300, 0, 2);
    app_n(0, 0, 30); app_n(0, 1, 5);
    build_events(); do_reset(); run_range(0, 70);
    chk("stall_valid", out_valid, 1);
    chk("stall_lost", lost_count, 1);
    chk_rec("stall", 200, 4, 3, 1'b0);
    run_range(70, n);
    chk("drained_valid", out_valid, 0);

    // pulse 5 cycles after an emit falls in dead time
    thr_i = 100; n = 0;
    app_n(0, 1, 4); app_n(200, 1, 3); app_n(0, 1, 5); app_n(250, 1, 3); app_n(0, 1, 40);
    build_events(); do_reset(); run_range(0, n);
    chk_rec("dead", 200, 4, 3, 1'b0);
    chk("dead_lost", lost_count, 0);

    // reset asserted mid-pulse with a held record and a nonzero lost count
    thr_i = 100; n = 0;
    app_n(0, 0, 4); app_n(300, 0, 3); app(0, 0); app_n(0, 0, 30); app_n(250, 0, 3);
    app(0, 0); app_n(0, 0, 30); app_n(200, 0, 10); app_n(0, 0, 20);
    build_events(); do_reset(); run_range(0, 76);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk_rec("mid_rst", 0, 0, 0, 1'b0);
    chk("mid_rst_lost", lost_count, 0);

    // counter restarts after reset
    thr_i = 100; n = 0;
    app_n(0, 1, 10); app(150, 1); app(400, 1); app(0, 1); app_n(0, 1, 20);
    build_events(); do_reset(); run_range(0, n);
    chk_rec("restart", 400, 11, 2, 1'b0);

    // random streams; the last uses a threshold whose low level saturates
    for (int s = 0; s < 6; s++) begin
      thr_i = (s == 5) ? -32766 : int'($urandom_range(0, 600)) - 300;
      n = 0;
      while (n < 1500) begin
        r   = int'($urandom_range(0, 9));
        len = ($urandom_range(0, 39) == 0) ? 600 : int'($urandom_range(1, 25));
        for (int i = 0; i < len; i++) begin
          if (r < 4)      v = thr_i - int'($urandom_range(5, 60));
          else if (r < 6) v = thr_i - int'($urandom_range(0, 4));
          else            v = thr_i + int'($urandom_range(1, 200));
          app(v, $urandom_range(0, 3) != 0);
        end
      end
      build_events(); do_reset(); run_range(0, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
